// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning HI/LO for the EX stage.
// Define MD_FAST_MULT_EN for single-cycle multiplies; division stays iterative.
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             E_md_start,
   input  logic [2:0]       E_md_op,
   input  logic [WIDTH-1:0] E_A,
   input  logic [WIDTH-1:0] E_B,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             E_md_signal,
   output logic             md_done
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

   state_t             state;
   logic [5:0]         cnt;
   logic               busy_q;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   divisor;

   logic               is_mul;
   logic               is_div;
   logic               is_signed;
   logic               accept_iter;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     div_tmp;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_nx;
   logic [WIDTH-1:0]   div_q_nx;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   assign is_mul    = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
   assign is_div    = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
   assign is_signed = ~E_md_op[0];
   assign a_neg     = is_signed & E_A[WIDTH-1];
   assign b_neg     = is_signed & E_B[WIDTH-1];
   assign a_mag     = a_neg ? -E_A : E_A;
   assign b_mag     = b_neg ? -E_B : E_B;

`ifdef MD_FAST_MULT_EN
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] fast_prod;

   assign accept_iter = is_div;
   assign ext_a       = is_signed ? {{WIDTH{E_A[WIDTH-1]}}, E_A} : {{WIDTH{1'b0}}, E_A};
   assign ext_b       = is_signed ? {{WIDTH{E_B[WIDTH-1]}}, E_B} : {{WIDTH{1'b0}}, E_B};
   assign fast_prod   = ext_a * ext_b;
`else
   logic [2*WIDTH-1:0] mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] mul_sum;
   logic [2*WIDTH-1:0] product;

   assign accept_iter = is_mul | is_div;
   assign mul_sum     = mul_acc + (mul_b[0] ? mul_a : '0);
   assign product     = neg_res ? -mul_sum : mul_sum;
`endif

   assign E_md_signal = busy_q | (E_md_start & (state == IDLE) & accept_iter);

   // Restoring step; with a zero divisor every quotient bit is 1 and the
   // remainder ends up as the dividend magnitude, so sign correction restores E_A.
   assign div_tmp    = {div_rem, div_q[WIDTH-1]};
   assign div_diff   = div_tmp - {1'b0, divisor};
   assign div_ge     = (div_tmp >= {1'b0, divisor});
   assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
   assign div_q_nx   = {div_q[WIDTH-2:0], div_ge};
   assign quot       = div_zero ? '1 : (neg_res ? -div_q_nx : div_q_nx);
   assign rem        = neg_rem ? -div_rem_nx : div_rem_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         md_done  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         div_q    <= '0;
         div_rem  <= '0;
         divisor  <= '0;
`ifndef MD_FAST_MULT_EN
         mul_a    <= '0;
         mul_b    <= '0;
         mul_acc  <= '0;
`endif
      end else begin
         md_done <= 1'b0;
         case (state)
            IDLE: begin
               if (E_md_start) begin
                  case (E_md_op)
                     OP_MULT, OP_MULTU: begin
`ifdef MD_FAST_MULT_EN
                        {hi, lo} <= fast_prod;
                        md_done  <= 1'b1;
`else
                        mul_a   <= {{WIDTH{1'b0}}, a_mag};
                        mul_b   <= b_mag;
                        mul_acc <= '0;
                        neg_res <= a_neg ^ b_neg;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= MUL;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        div_q    <= a_mag;
                        divisor  <= b_mag;
                        div_rem  <= '0;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (E_B == '0);
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= DIV;
                     end
                     OP_MTHI: hi <= E_A;
                     OP_MTLO: lo <= E_A;
                     default: ;
                  endcase
               end
            end
`ifndef MD_FAST_MULT_EN
            MUL: begin
               mul_acc <= mul_sum;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               cnt     <= cnt + 6'd1;
               if (cnt == LAST_STEP) begin
                  {hi, lo} <= product;
                  busy_q   <= 1'b0;
                  md_done  <= 1'b1;
                  state    <= IDLE;
               end
            end
`endif
            DIV: begin
               div_rem <= div_rem_nx;
               div_q   <= div_q_nx;
               cnt     <= cnt + 6'd1;
               if (cnt == LAST_STEP) begin
                  hi      <= rem;
                  lo      <= quot;
                  busy_q  <= 1'b0;
                  md_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;

`ifdef MD_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        E_md_start;
   logic [2:0]  E_md_op;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        E_md_signal;
   logic        md_done;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] expHi = '0;
   logic [31:0] expLo = '0;

   md_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .E_md_start (E_md_start),
      .E_md_op    (E_md_op),
      .E_A        (E_A),
      .E_B        (E_B),
      .hi         (hi),
      .lo         (lo),
      .E_md_signal(E_md_signal),
      .md_done    (md_done)
   );

   always #5 clk = ~clk;

   // Reference behaviour straight from the architectural rules, returns {hi, lo}.
   function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, b,
                                            input logic [31:0] curHi, curLo);
      longint sa64, sb64, p;
      int     sa, sb;
      case (op)
         3'd0: begin
            sa64 = $signed(a);
            sb64 = $signed(b);
            p = sa64 * sb64;
            return p;
         end
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         3'd4: return {a, curLo};
         3'd5: return {curHi, a};
         default: return {curHi, curLo};
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op from IDLE and follows it to completion (called at posedge+1).
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, b, input string tag);
      logic [63:0] expv;
      bit          isMd;
      bit          iter;
      int          busyCycles;
      expv = refModel(op, a, b, expHi, expLo);
      isMd = (op <= 3'd3);
      iter = (op == 3'd2 || op == 3'd3) || (op <= 3'd1 && !FAST);
      E_md_start = 1'b1;
      E_md_op    = op;
      E_A        = a;
      E_B        = b;
      #1;
      checkOutput({tag, "_busyStart"}, 32'(E_md_signal), 32'(iter));
      busyCycles = E_md_signal ? 1 : 0;
      @(posedge clk);
      #1;
      E_md_start = 1'b0;
      E_A        = $urandom;
      E_B        = $urandom;
      if (iter) begin
         for (int k = 0; k < 40 && E_md_signal; k++) begin
            busyCycles++;
            tick();
         end
         checkOutput({tag, "_busyLen"}, 32'(busyCycles), 32'd33);
      end
      expHi = expv[63:32];
      expLo = expv[31:0];
      checkOutput({tag, "_done"}, 32'(md_done), 32'(isMd));
      checkOutput({tag, "_hi"}, hi, expHi);
      checkOutput({tag, "_lo"}, lo, expLo);
      tick();
      checkOutput({tag, "_doneOff"}, 32'(md_done), 32'd0);
   endtask

   initial begin
      logic [63:0] expv;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      rst_n      = 1'b0;
      E_md_start = 1'b0;
      E_md_op    = 3'd0;
      E_A        = '0;
      E_B        = '0;
      repeat (2) tick();
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_lo", lo, 32'd0);
      checkOutput("rst_busy", 32'(E_md_signal), 32'd0);
      checkOutput("rst_done", 32'(md_done), 32'd0);
      #2 rst_n = 1'b1;
      tick();

      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      checkOutput("multu_max_hiConst", hi, 32'hFFFF_FFFE);
      applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg");
      checkOutput("mult_neg_loConst", lo, 32'hFFFF_FFF1);
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      applyStimulus(3'd2, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
      applyStimulus(3'd3, 32'd7, 32'd2, "divu_7_2");
      applyStimulus(3'd2, 32'd5, 32'd0, "div_by0");
      applyStimulus(3'd3, 32'hDEAD_BEEF, 32'd0, "divu_by0");
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      applyStimulus(3'd4, 32'h5555_AAAA, 32'd0, "mthi");
      applyStimulus(3'd6, 32'h1111_2222, 32'd3, "op6_ignored");

      // Busy blocking: mthi and mult issued mid-divide must be dropped.
      expv = refModel(3'd2, 32'd100, 32'd7, expHi, expLo);
      E_md_start = 1'b1;
      E_md_op    = 3'd2;
      E_A        = 32'd100;
      E_B        = 32'd7;
      tick();
      E_md_start = 1'b0;
      repeat (4) tick();
      E_md_start = 1'b1;
      E_md_op    = 3'd4;
      E_A        = 32'h1234;
      tick();
      E_md_op    = 3'd0;
      E_A        = 32'd2;
      E_B        = 32'd3;
      tick();
      E_md_start = 1'b0;
      checkOutput("blk_busy", 32'(E_md_signal), 32'd1);
      for (int k = 0; k < 40 && !md_done; k++) tick();
      expHi = expv[63:32];
      expLo = expv[31:0];
      checkOutput("blk_done", 32'(md_done), 32'd1);
      checkOutput("blk_hi", hi, 32'd2);
      checkOutput("blk_lo", lo, 32'd14);
      tick();
      applyStimulus(3'd5, 32'hAB, 32'd0, "blk_mtlo");

      // Asynchronous reset in the middle of a divu.
      E_md_start = 1'b1;
      E_md_op    = 3'd3;
      E_A        = $urandom;
      E_B        = $urandom | 32'd1;
      tick();
      E_md_start = 1'b0;
      repeat (9) tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_hi", hi, 32'd0);
      checkOutput("arst_lo", lo, 32'd0);
      checkOutput("arst_busy", 32'(E_md_signal), 32'd0);
      checkOutput("arst_done", 32'(md_done), 32'd0);
      expHi = '0;
      expLo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      applyStimulus(3'd1, 32'd6, 32'd7, "post_rst_multu");

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'd0;
         if (op == 3'd2 && $urandom_range(0, 7) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         applyStimulus(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
